// File: rtl/stuff_destuff_param.sv
// rtl/stuff_destuff_param.sv - bit destuffer for dynamic (run-length) and fixed (CAN FD CRC) stuffing
// Optional STF_CNT counter is built only when STUFF_CNT_EN is defined.
module stuff_destuff_param #(
  parameter int RUN_LEN      = 5,
  parameter int FIXED_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SP_IN,
  input  logic       RX,
  input  logic       F_STF,
  input  logic       FIXED,
  output logic       SP,
  output logic       RX_OUT,
  output logic       STF_DROP,
  output logic       STF_ERR,
  output logic [2:0] STF_CNT
);

  localparam logic [3:0] RUN_L = 4'(RUN_LEN);
  localparam logic [3:0] FIX_L = 4'(FIXED_PERIOD);

  logic       last_q, last_d;
  logic [3:0] run_q, run_d;
  logic       exp_q, exp_d;
  logic [3:0] fix_q, fix_d;
  logic       fprev_q, fprev_d;
  logic       sp_q, sp_d;
  logic       rx_out_q, rx_out_d;
  logic       drop_q, drop_d;
  logic       err_q, err_d;

  always_comb begin
    last_d   = last_q;
    run_d    = run_q;
    exp_d    = exp_q;
    fix_d    = fix_q;
    fprev_d  = fprev_q;
    sp_d     = 1'b0;
    rx_out_d = rx_out_q;
    drop_d   = 1'b0;
    err_d    = 1'b0;
    if (SP_IN) begin
      fprev_d = FIXED;
      last_d  = RX;
      if (!F_STF) begin
        sp_d     = 1'b1;
        rx_out_d = RX;
        run_d    = 4'd0;
        exp_d    = 1'b0;
      end else if (FIXED) begin
        // Clearing the run here makes the first dynamic bit after fixed mode count as 1.
        run_d = 4'd0;
        exp_d = 1'b0;
        if (!fprev_q || fix_q == FIX_L) begin
          fix_d  = 4'd0;
          drop_d = (RX != last_q);
          err_d  = (RX == last_q);
        end else begin
          fix_d    = fix_q + 4'd1;
          sp_d     = 1'b1;
          rx_out_d = RX;
        end
      end else if (exp_q) begin
        run_d  = 4'd1;
        exp_d  = 1'b0;
        drop_d = (RX != last_q);
        err_d  = (RX == last_q);
      end else begin
        sp_d     = 1'b1;
        rx_out_d = RX;
        run_d    = (RX == last_q) ? run_q + 4'd1 : 4'd1;
        exp_d    = (run_d == RUN_L);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= 1'b1;
      run_q    <= 4'd0;
      exp_q    <= 1'b0;
      fix_q    <= 4'd0;
      fprev_q  <= 1'b0;
      sp_q     <= 1'b0;
      rx_out_q <= 1'b0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      last_q   <= last_d;
      run_q    <= run_d;
      exp_q    <= exp_d;
      fix_q    <= fix_d;
      fprev_q  <= fprev_d;
      sp_q     <= sp_d;
      rx_out_q <= rx_out_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  assign SP       = sp_q;
  assign RX_OUT   = rx_out_q;
  assign STF_DROP = drop_q;
  assign STF_ERR  = err_q;

`ifdef STUFF_CNT_EN
  logic [2:0] cnt_q;

  // Only dynamic stuff bits that were dropped are counted; wraps naturally at 8.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 3'd0;
    end else if (SP_IN) begin
      if (!F_STF) begin
        cnt_q <= 3'd0;
      end else if (!FIXED && exp_q && (RX != last_q)) begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  assign STF_CNT = cnt_q;
`else
  assign STF_CNT = 3'd0;
`endif

endmodule
